// File: rtl/t_counter_pkg.sv
// Shared constants and helpers for the toggle-flop based counter.
// Holds the saturate-mode constants and the terminal-value helper.
package t_counter_pkg;

    // Values for the SATURATE parameter of t_counter.
    localparam bit SAT_WRAP = 1'b0;
    localparam bit SAT_HOLD = 1'b1;

    // Highest count value, MODULO-1, reduced to WIDTH bits.
    // Inputs: width - counter width in bits, modulo - number of states.
    // 64-bit arithmetic keeps MODULO == 2**32 representable.
    function automatic longint unsigned max_count(
        input int              width,
        input longint unsigned modulo
    );
        longint unsigned mask;
        mask = (64'd1 << width) - 64'd1;
        return (modulo - 64'd1) & mask;
    endfunction

endpackage

// File: rtl/t_counter_t_ff_cell.sv
// Single T flip-flop cell, one bit of the counter register bank.
// Ports: CLK clock, RESET sync active-high clear, T toggle enable, Q state.
module t_ff_cell (
    input  logic CLK,
    input  logic RESET,
    input  logic T,
    output logic Q
);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            Q <= 1'b0;
        end else if (T) begin
            Q <= ~Q;
        end
    end

endmodule

// File: rtl/t_counter.sv
// Up/down modulo counter built from a bank of T flip-flop cells.
// Ports: CLK, RESET (sync, active-high), EN, UP, LOAD, D -> Q, TC, OVF.
module t_counter
    import t_counter_pkg::*;
#(
    parameter int              WIDTH    = 4,
    parameter longint unsigned MODULO   = 64'd1 << WIDTH,
    parameter bit              SATURATE = SAT_WRAP
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             UP,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             OVF
);

    localparam logic [WIDTH-1:0] MAX_Q =
        WIDTH'(max_count(WIDTH, MODULO));
    localparam logic [WIDTH-1:0] ZERO_Q = '0;
    localparam logic [WIDTH-1:0] ONE_Q  = WIDTH'(1);

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] t_vec;
    logic             at_max;
    logic             at_zero;
    logic             tc;
    logic             ovf;

    assign at_max  = (q == MAX_Q);
    assign at_zero = (q == ZERO_Q);

    // Terminal count: the coming edge produces a wrap or saturate event.
    assign tc = EN && !LOAD && (UP ? at_max : at_zero);

    // Target value for the next edge; reset is applied inside the cells.
    always_comb begin
        q_next = q;
        if (LOAD) begin
            q_next = (D > MAX_Q) ? MAX_Q : D;
        end else if (EN) begin
            if (UP) begin
                if (!at_max) begin
                    q_next = q + ONE_Q;
                end else if (SATURATE == SAT_WRAP) begin
                    q_next = ZERO_Q;
                end
            end else begin
                if (!at_zero) begin
                    q_next = q - ONE_Q;
                end else if (SATURATE == SAT_WRAP) begin
                    q_next = MAX_Q;
                end
            end
        end
    end

    // Every transition, including load and wrap, is a toggle pattern.
    assign t_vec = q ^ q_next;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        t_ff_cell u_cell (
            .CLK   (CLK),
            .RESET (RESET),
            .T     (t_vec[i]),
            .Q     (q[i])
        );
    end

    // OVF is tc delayed one edge; reset drops any pending event.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ovf <= 1'b0;
        end else begin
            ovf <= tc;
        end
    end

    assign Q   = q;
    assign TC  = tc;
    assign OVF = ovf;

endmodule

// File: tb/tb_t_counter.sv
// Self-checking bench for t_counter: three configurations share stimulus.
// A: W4/M10 wrap, B: W4/M10 saturate, C: W3/M8 wrap (full binary range).
module tb_t_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       load = 1'b0;
    logic [3:0] d = '0;

    logic [3:0] qa, qb;
    logic [2:0] qc;
    logic       tca, tcb, tcc;
    logic       ova, ovb, ovc;

    int tests = 0;
    int fails = 0;

    int mod_v[3] = '{10, 10, 8};
    int sat_v[3] = '{0, 1, 0};
    int wid_v[3] = '{4, 4, 3};
    int mq[3];
    int mo[3];

    always #5 clk = ~clk;

    t_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b0)) u_a (
        .CLK(clk), .RESET(rst), .EN(en), .UP(up), .LOAD(load),
        .D(d), .Q(qa), .TC(tca), .OVF(ova)
    );

    t_counter #(.WIDTH(4), .MODULO(10), .SATURATE(1'b1)) u_b (
        .CLK(clk), .RESET(rst), .EN(en), .UP(up), .LOAD(load),
        .D(d), .Q(qb), .TC(tcb), .OVF(ovb)
    );

    t_counter #(.WIDTH(3), .MODULO(8), .SATURATE(1'b0)) u_c (
        .CLK(clk), .RESET(rst), .EN(en), .UP(up), .LOAD(load),
        .D(d[2:0]), .Q(qc), .TC(tcc), .OVF(ovc)
    );

    task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[%0d]: got %0d expected %0d", tag, k, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_q(int k);
        case (k)
            0: return {28'd0, qa};
            1: return {28'd0, qb};
            default: return {29'd0, qc};
        endcase
    endfunction

    function automatic logic [31:0] obs_tc(int k);
        case (k)
            0: return {31'd0, tca};
            1: return {31'd0, tcb};
            default: return {31'd0, tcc};
        endcase
    endfunction

    function automatic logic [31:0] obs_ovf(int k);
        case (k)
            0: return {31'd0, ova};
            1: return {31'd0, ovb};
            default: return {31'd0, ovc};
        endcase
    endfunction

    // Reference behaviour of one counter for one rising edge.
    task automatic model_edge(int k);
        int top;
        int dv;
        top = mod_v[k] - 1;
        dv = int'(d) % (1 << wid_v[k]);
        if (rst) begin
            mq[k] = 0;
            mo[k] = 0;
        end else if (load) begin
            mq[k] = (dv > top) ? top : dv;
            mo[k] = 0;
        end else if (en && up) begin
            if (mq[k] == top) begin
                mo[k] = 1;
                if (sat_v[k] == 0) mq[k] = 0;
            end else begin
                mo[k] = 0;
                mq[k] = mq[k] + 1;
            end
        end else if (en) begin
            if (mq[k] == 0) begin
                mo[k] = 1;
                if (sat_v[k] == 0) mq[k] = top;
            end else begin
                mo[k] = 0;
                mq[k] = mq[k] - 1;
            end
        end else begin
            mo[k] = 0;
        end
    endtask

    function automatic int model_tc(int k);
        if (!en || load) return 0;
        if (up) return (mq[k] == mod_v[k] - 1) ? 1 : 0;
        return (mq[k] == 0) ? 1 : 0;
    endfunction

    // One clock cycle: drive, check TC, clock, check Q and OVF.
    task automatic step(bit r, bit e, bit u, bit l, logic [3:0] dv);
        @(negedge clk);
        rst = r;
        en = e;
        up = u;
        load = l;
        d = dv;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("tc", k, obs_tc(k), 32'(model_tc(k)));
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) model_edge(k);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("q", k, obs_q(k), 32'(mq[k]));
            chk("ovf", k, obs_ovf(k), 32'(mo[k]));
        end
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            mq[k] = 0;
            mo[k] = 0;
        end

        // Reset, then count up through the wrap.
        step(1, 0, 0, 0, 4'd0);
        for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 4'd0);

        // Load 2 and count down through zero.
        step(0, 0, 0, 1, 4'd2);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 4'd0);

        // Load 8 and count up into the top (saturates on B).
        step(0, 0, 0, 1, 4'd8);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 4'd0);

        // Clamp with EN high, then load beats a pending wrap.
        step(0, 1, 1, 1, 4'd13);
        step(0, 1, 1, 1, 4'd4);
        step(0, 0, 0, 0, 4'd0);

        // Reset on the edge where TC is high.
        step(0, 0, 0, 1, 4'd9);
        step(1, 1, 1, 0, 4'd0);
        step(0, 0, 1, 0, 4'd0);

        // Full-range rollover on C, then hold with EN low.
        step(0, 0, 0, 1, 4'd7);
        step(0, 1, 1, 0, 4'd0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 4'd0);

        // Direction change while enabled.
        step(0, 1, 0, 0, 4'd0);
        step(0, 1, 1, 0, 4'd0);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 3) != 0),
                 1'($urandom),
                 ($urandom_range(0, 7) == 0),
                 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
